// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM encoding and ALU/branch helpers shared by the execute stage.
package exec_pkg;
  localparam logic [3:0] OP_ADDQ   = 4'd0;
  localparam logic [3:0] OP_SUBQ   = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_BIS    = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SLL    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_CMPEQ  = 4'd8;
  localparam logic [3:0] OP_CMPLT  = 4'd9;
  localparam logic [3:0] OP_CMPULT = 4'd10;
  localparam logic [3:0] OP_MULQ   = 4'd11;
  localparam logic [3:0] OP_UMULH  = 4'd12;
  localparam logic [3:0] OP_BEQ    = 4'd13;
  localparam logic [3:0] OP_BNE    = 4'd14;
  localparam logic [3:0] OP_BLT    = 4'd15;
  localparam logic [4:0] REG_ZERO  = 5'd31;
  typedef enum logic {S_IDLE, S_MUL} state_t;
  function automatic logic is_mul(input logic [3:0] op);
    return op == OP_MULQ || op == OP_UMULH;
  endfunction
  function automatic logic is_branch(input logic [3:0] op);
    return op >= OP_BEQ;
  endfunction
  function automatic logic branch_cond(input logic [3:0] op, input logic [63:0] ra);
    return op == OP_BEQ ? ra == 64'd0 : op == OP_BNE ? ra != 64'd0 : ra[63];
  endfunction
  // Multiply opcodes return zero here; their result comes from mul_iter.
  function automatic logic [63:0] alu_calc(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    case (op)
      OP_SUBQ:   r = a - b;
      OP_AND:    r = a & b;
      OP_BIS:    r = a | b;
      OP_XOR:    r = a ^ b;
      OP_SLL:    r = a << b[5:0];
      OP_SRL:    r = a >> b[5:0];
      OP_SRA:    r = $signed(a) >>> b[5:0];
      OP_CMPEQ:  r = {63'd0, a == b};
      OP_CMPLT:  r = {63'd0, $signed(a) < $signed(b)};
      OP_CMPULT: r = {63'd0, a < b};
      OP_MULQ:   r = 64'd0;
      OP_UMULH:  r = 64'd0;
      default:   r = a + b;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative unsigned 64x64->128 multiplier retiring MUL_BITS_PER_CYCLE bits per cycle.
module mul_iter
  import exec_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic         busy,
  output logic         done,
  output logic [127:0] product
);
  localparam int ITER = 64 / MUL_BITS_PER_CYCLE;
  logic [127:0] mcand, acc, pp;
  logic [63:0]  mplier;
  logic [6:0]   cnt;
  always_comb begin
    pp = '0;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++)
      pp = pp + (mplier[k] ? mcand << k : 128'd0);
  end
  // product is the accumulator after this cycle's step, so the final value is usable at the done edge.
  assign product = acc + pp;
  assign done    = busy && cnt == 7'(ITER - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      mcand  <= {64'd0, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << MUL_BITS_PER_CYCLE;
      mplier <= mplier >> MUL_BITS_PER_CYCLE;
      cnt    <= cnt + 7'd1;
      busy   <= !done;
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU/compare/shift/branch plus stalling iterative multiply, registered write-back.
module execute_stage
  import exec_pkg::*;
#(
  parameter int MUL_BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  alu_op,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic [63:0] ra_val,
  input  logic [4:0]  dest_in,
  output logic [63:0] result,
  output logic [4:0]  dest_out,
  output logic        wr_en,
  output logic        branch_taken,
  output logic        stall
);
  state_t       state, state_n;
  logic         mul_start, mul_done, mul_busy, mul_hi;
  logic [4:0]   mul_dest, dest_d;
  logic [127:0] prod;
  logic [63:0]  result_d;
  logic         wr_d, br_d;
  assign mul_start = state == S_IDLE && valid_in && is_mul(alu_op);
  assign stall     = mul_busy;
  mul_iter #(.MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)) u_mul (
    .clk(clk), .reset(reset), .start(mul_start), .a(op_a), .b(op_b),
    .busy(mul_busy), .done(mul_done), .product(prod)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == S_IDLE ? (mul_start ? S_MUL : S_IDLE) : (mul_done ? S_IDLE : S_MUL);
  end
  always_comb begin
    result_d = result;
    dest_d   = dest_out;
    wr_d     = 1'b0;
    br_d     = 1'b0;
    if (state == S_MUL && mul_done) begin
      result_d = mul_hi ? prod[127:64] : prod[63:0];
      dest_d   = mul_dest;
      wr_d     = mul_dest != REG_ZERO;
    end else if (state == S_IDLE && valid_in && !is_mul(alu_op)) begin
      result_d = alu_calc(alu_op, op_a, op_b);
      dest_d   = dest_in;
      wr_d     = !is_branch(alu_op) && dest_in != REG_ZERO;
      br_d     = is_branch(alu_op) && branch_cond(alu_op, ra_val);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      dest_out     <= '0;
      wr_en        <= 1'b0;
      branch_taken <= 1'b0;
      mul_hi       <= 1'b0;
      mul_dest     <= '0;
    end else begin
      result       <= result_d;
      dest_out     <= dest_d;
      wr_en        <= wr_d;
      branch_taken <= br_d;
      if (mul_start) begin
        mul_hi   <= alu_op == OP_UMULH;
        mul_dest <= dest_in;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: per-cycle scoreboard of execute_stage against a behavioural model.
module tb_execute_stage;
  localparam int ITER = 32;
  logic clk = 0, reset = 0, valid_in = 0;
  logic [3:0] alu_op = 0;
  logic [63:0] op_a = 0, op_b = 0, ra_val = 0;
  logic [4:0] dest_in = 0;
  logic [63:0] result;
  logic [4:0] dest_out;
  logic wr_en, branch_taken, stall;
  typedef struct packed {logic [63:0] res; logic [4:0] dest; logic wr; logic br; logic st;} exp_t;
  exp_t q[$];
  int ncmp = 0, nerr = 0;
  logic [63:0] m_res = 0;
  logic [4:0] m_dest = 0, mul_dest = 0;
  logic [127:0] mul_prod = 0;
  logic mul_hi = 0;
  int mul_left = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .ra_val(ra_val), .dest_in(dest_in), .result(result), .dest_out(dest_out), .wr_en(wr_en),
    .branch_taken(branch_taken), .stall(stall)
  );

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int sh = int'(b[5:0]);
    logic [127:0] ext = {{64{a[63]}}, a};
    case (op)
      1: return a + ~b + 64'd1;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * (64'd1 << sh);
      6: return a / (64'd1 << sh);
      7: begin ext = ext >> sh; return ext[63:0]; end
      8: return (a == b) ? 64'd1 : 64'd0;
      9: return (a[63] != b[63]) ? {63'd0, a[63]} : ((a < b) ? 64'd1 : 64'd0);
      10: return (a < b) ? 64'd1 : 64'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic step(input bit rst, input bit v, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] ra, input logic [4:0] dest);
    exp_t e;
    @(negedge clk);
    reset = rst; valid_in = v; alu_op = op; op_a = a; op_b = b; ra_val = ra; dest_in = dest;
    e = '0;
    if (rst) begin
      #1;
      cmp("rst_result", result, 64'd0);
      cmp("rst_dest", 64'(dest_out), 64'd0);
      cmp("rst_wr_en", 64'(wr_en), 64'd0);
      cmp("rst_branch", 64'(branch_taken), 64'd0);
      cmp("rst_stall", 64'(stall), 64'd0);
      m_res = 0; m_dest = 0; mul_left = 0;
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        m_res = mul_hi ? mul_prod[127:64] : mul_prod[63:0];
        m_dest = mul_dest;
        e.wr = mul_dest != 5'd31;
      end else e.st = 1;
    end else if (v && (op == 11 || op == 12)) begin
      mul_left = ITER;
      mul_prod = {64'd0, a} * {64'd0, b};
      mul_hi = op == 12;
      mul_dest = dest;
      e.st = 1;
    end else if (v) begin
      m_res = ref_alu(op, a, b);
      m_dest = dest;
      e.wr = op < 13 && dest != 5'd31;
      e.br = op == 13 ? ra == 0 : op == 14 ? ra != 0 : op == 15 ? $signed(ra) < 0 : 1'b0;
    end
    e.res = m_res;
    e.dest = m_dest;
    q.push_back(e);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 70));
      1: return 64'd0 - 64'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic garbage(input int n);
    repeat (n) step(0, 1, 4'($urandom), rnd64(), rnd64(), rnd64(), 5'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 4'($urandom), rnd64(), rnd64(), rnd64(), 5'($urandom));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("result", result, e.res);
        cmp("dest_out", 64'(dest_out), 64'(e.dest));
        cmp("wr_en", 64'(wr_en), 64'(e.wr));
        cmp("branch_taken", 64'(branch_taken), 64'(e.br));
        cmp("stall", 64'(stall), 64'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1 reset = 1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 64'd5, 64'd7, 0, 5'd3);
    step(0, 1, 7, 64'h8000_0000_0000_0000, 64'd4, 0, 5'd4);
    step(0, 1, 9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 5'd5);
    step(0, 1, 10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 5'd6);
    step(0, 1, 11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, 5'd8);
    garbage(ITER);
    step(0, 1, 12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, 5'd9);
    garbage(ITER);
    step(0, 1, 11, rnd64(), rnd64(), 0, 5'd31);
    garbage(ITER);
    step(0, 1, 13, 64'h1000, 64'h20, 64'd0, 5'd10);
    step(0, 1, 13, 64'h1000, 64'h20, 64'd1, 5'd10);
    step(0, 1, 0, 64'd9, 64'd9, 0, 5'd31);
    idle(1);
    repeat (600) step(0, $urandom_range(0, 4) != 0, 4'($urandom), rnd64(), rnd64(),
                      ($urandom_range(0, 2) == 0) ? 64'd0 : rnd64(), 5'($urandom));
    idle(ITER + 1);
    step(0, 1, 11, 64'd123, 64'd456, 0, 5'd12);
    garbage(10);
    step(1, 1, 0, 64'd50, 64'd50, 0, 5'd1);
    step(1, 1, 0, 64'd50, 64'd50, 0, 5'd1);
    step(0, 1, 0, 64'd1, 64'd1, 0, 5'd2);
    idle(ITER + 5);
    repeat (3) @(posedge clk);
    #2;
    cmp("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
# execute_stage

Integer execute stage directly downstream of the register-read/operand-select stage. Consumes the registered operand pair (A-side: Ra, sign-extended displacement, PC+4 or zero; B-side: Rb or sign-extended literal) plus the delayed Ra value. Performs one ALU, compare, shift, branch-test or multiply operation and registers the write-back triple (result, destination, enable) and the branch decision. Single-cycle for all operations except MULQ/UMULH, which run on an iterative multiplier and stall the pipeline.

## Interface
- `MUL_BITS_PER_CYCLE`, default 2: multiplier bits retired per cycle; legal values 1, 2, 4. Multiply iterations = 64/`MUL_BITS_PER_CYCLE`.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `valid_in` in 1: operation on inputs is valid this cycle.
- `alu_op` in 4: operation code (see Operation).
- `op_a` in 64: A operand from upstream select mux.
- `op_b` in 64: B operand from upstream select mux.
- `ra_val` in 64: delayed Ra value, used for branch condition tests.
- `dest_in` in 5: destination register number.
- `result` out 64: registered result.
- `dest_out` out 5: registered destination.
- `wr_en` out 1: registered register-file write enable, one-cycle pulse.
- `branch_taken` out 1: registered branch decision, one-cycle pulse.
- `stall` out 1: registered; upstream holds inputs while high.

## Operation
- Opcodes: 0 ADDQ a+b; 1 SUBQ a−b; 2 AND; 3 BIS (or); 4 XOR; 5 SLL a<<b[5:0]; 6 SRL logical; 7 SRA arithmetic; 8 CMPEQ; 9 CMPLT signed; 10 CMPULT; 11 MULQ low 64 of product; 12 UMULH high 64 of unsigned 128-bit product; 13 BEQ; 14 BNE; 15 BLT.
- Compares produce 64'd1 or 64'd0. All arithmetic is modulo 2^64 with no overflow traps.
- Branch ops (13–15):
  - `result` = a+b (target address).
  - `wr_en` = 0.
  - `branch_taken` = (ra_val==0), (ra_val!=0) or (ra_val signed <0) respectively.
- `wr_en` = 1 only for valid non-branch ops with `dest_in` != 31. R31 writes are suppressed here.
- `valid_in` low: `wr_en` and `branch_taken` go 0; `result` and `dest_out` hold their previous values.
- FSM states: IDLE, MUL.
  - IDLE, valid_in with op 11/12: latch a, b, op and dest; clear 128-bit accumulator and iteration counter; go to MUL. No output pulse this cycle.
  - MUL: each cycle add the partial product for the next `MUL_BITS_PER_CYCLE` multiplier bits (unsigned), then shift. After the final iteration, register `result` (low or high half), `dest_out`, and `wr_en` (dest≠31); return to IDLE.
  - IDLE, any other valid op: complete in one cycle; stay in IDLE.
- `stall` is high in every cycle the FSM is in MUL. Inputs are ignored while `stall` is high.
- Reset, including mid-multiply: state IDLE; `result`=0, `dest_out`=0, `wr_en`=0, `branch_taken`=0, `stall`=0; the aborted multiply produces no write-back.

## Timing
- Single-cycle op sampled at edge N: outputs valid after edge N, held for one cycle (pulses).
- Multiply sampled at edge N:
  - `stall` is high after edge N through edge N+I−1, where I = 64/`MUL_BITS_PER_CYCLE`.
  - Result and `wr_en` are valid after edge N+I, the same edge at which `stall` falls.
  - The next operation may be presented in the cycle after `stall` falls.
- Back-to-back single-cycle ops: one per cycle, no bubbles.
- Back-to-back multiplies: the second is accepted at the first edge with `stall` low.

## Structure
- Shared package `exec_pkg`:
  - opcode localparams `OP_ADDQ` … `OP_BLT`;
  - FSM state encoding;
  - `REG_ZERO` = 5'd31.
- Sub-module `mul_iter`: iterative unsigned 64×64→128 multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done pulse, product.
  - Parameterised by `MUL_BITS_PER_CYCLE`.
  - Receives the same `reset`.
- Top level holds the combinational ALU, branch test, output registers and stall logic.

## Test plan
- ADDQ a=5, b=7, dest=3 -> next cycle `result`=12, `dest_out`=3, `wr_en`=1, `branch_taken`=0, `stall`=0.
- SRA a=0x8000_0000_0000_0000, b=4 -> `result`=0xF800_0000_0000_0000. CMPLT a=−1, b=0 -> 1. CMPULT on the same operands -> 0.
- MULQ a=0xFFFF_FFFF_FFFF_FFFF, b=3 with default parameter -> `stall` high 32 cycles, then `result`=0xFFFF_FFFF_FFFF_FFFD with `wr_en` pulse. UMULH on the same operands -> `result`=2.
- BEQ with ra_val=0, a=0x1000, b=0x20 -> `branch_taken`=1, `result`=0x1020, `wr_en`=0. Repeat with ra_val=1 -> `branch_taken`=0.
- ADDQ with dest=31 -> `wr_en`=0 and `result` still updated. `valid_in`=0 cycle -> `wr_en`=0, `result` unchanged.
- Assert `reset` 10 cycles into a MULQ -> all outputs 0 immediately and no later `wr_en`. After release, ADDQ 1+1 -> `result`=2 one cycle later.
